vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Pixel-clock VGA timing generator, 640x480@60 by default. Produces DrawX/DrawY/blank
//  for the sprite mapper stages, plus hs/vs for the VGA pins and a frame_start strobe.
//  Optional sprite-window decode gives per-pixel sprite ROM addresses and a tear-free
//  sprite origin.
// PARAMETERS
//  H_VISIBLE 640 ; H_FP 16 ; H_SYNC 96 ; H_BP 48  -- horizontal pixels (total 800)
//  V_VISIBLE 480 ; V_FP 10 ; V_SYNC 2  ; V_BP 33  -- vertical lines (total 525)
//  SPR_W 21 ; SPR_H 45                            -- sprite window size, SPRITE_WINDOW_EN only
// PORTS
//  vga_clk      in   1   pixel clock; all logic on its rising edge
//  reset        in   1   synchronous, active-high
//  DrawX        out  10  current pixel column, 0..799
//  DrawY        out  10  current line, 0..524
//  hs           out  1   horizontal sync, active-low
//  vs           out  1   vertical sync, active-low
//  blank        out  1   1 = visible region (DrawX<H_VISIBLE && DrawY<V_VISIBLE)
//  frame_start  out  1   1-cycle pulse while outputs show (0,0)
//  spr_x_in     in   10  sprite origin X (SPRITE_WINDOW_EN only)
//  spr_y_in     in   10  sprite origin Y (SPRITE_WINDOW_EN only)
//  sprite_on    out  1   pixel lies inside the sprite window (SPRITE_WINDOW_EN only)
//  sprite_addr  out  11  (DrawY-oy)*SPR_W + (DrawX-ox); 0 when sprite_on=0 (SPRITE_WINDOW_EN only)
// BEHAVIOUR
//  - Internal counters h_cnt 0..H_TOT-1 and v_cnt 0..V_TOT-1.
//    h_cnt wraps to 0 after H_TOT-1; v_cnt increments only on an h wrap,
//    and wraps to 0 after V_TOT-1.
//  - Every output is registered: it is decode(h_cnt,v_cnt) of the previous cycle.
//    All outputs are mutually aligned; latency is 1 cycle from counter to output.
//  - hs=0 iff H_VISIBLE+H_FP <= x < H_VISIBLE+H_FP+H_SYNC (656..751).
//    vs=0 iff V_VISIBLE+V_FP <= y < V_VISIBLE+V_FP+V_SYNC (490..491).
//  - frame_start=1 iff the decoded (x,y)=(0,0): exactly once per 420000 cycles.
//  - Reset (any cycle, including mid-frame): counters <- 0.
//    Outputs <- DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_start=0,
//    sprite_on=0, sprite_addr=0.
//    On the first edge after reset drops, outputs show (0,0): blank=1, frame_start=1.
//  - No handshake; the generator free-runs. Widths: counters 10b with no overflow
//    (max 799/524). sprite_addr is computed in 11b; max is 21*45-1=944.
// CONFIGURATION
//  - SPRITE_WINDOW_EN defined:
//    - Shadow origin ox/oy (10b, reset 0) is loaded from spr_x_in/spr_y_in only on the
//      cycle the counters are at (0,0). Mid-frame input changes therefore take effect
//      next frame (no tearing).
//    - sprite_on = blank && ox<=x<ox+SPR_W && oy<=y<oy+SPR_H.
//      Compares are done in 11b so windows near x=639 or y=479 do not wrap.
//    - sprite_addr is valid in the same cycle as sprite_on.
//  - SPRITE_WINDOW_EN undefined: the spr_* ports, shadow registers and window logic are
//    absent. Timing outputs are identical.
// TESTING
//  - Reset held 5 cycles then released -> outputs at reset values during reset.
//    Next edge: DrawX=0, DrawY=0, blank=1, frame_start=1. DrawX=1 the cycle after.
//  - Free-run 1 line -> blank falls at DrawX=640; hs low for DrawX 656..751 (96 cycles).
//    After DrawX=799: DrawX=0, DrawY=1.
//  - Free-run 2 frames -> vs low exactly on lines 490,491 (1600 cycles).
//    frame_start pulses 420000 cycles apart. DrawY wraps 524->0.
//  - Assert reset at DrawX=300, DrawY=200 -> next edge DrawX=0, DrawY=0, hs=vs=1, blank=0.
//    Resume from (0,0).
//  - SPRITE_WINDOW_EN, spr=(100,50) -> sprite_on at (100,50) with addr 0;
//    (120,94) addr 944; (121,50) off. Change spr to (0,0) mid-frame -> no effect until
//    next frame_start.
//  - SPRITE_WINDOW_EN, spr=(630,470) -> sprite_on only for x 630..639, y 470..479.
//    Never on in blanking; no wrap to x=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Pixel-clock VGA timing generator (640x480@60 with default parameters).
//   Two free-running counters walk the full raster.  Every output is a
//   registered decode of the counters, so all outputs share one cycle of
//   latency and stay mutually aligned.
//
//   Optional feature, enabled by defining SPRITE_WINDOW_EN:
//     a sprite window decode that produces sprite_on / sprite_addr.  The
//     window origin is shadowed once per frame, when the counters sit at
//     (0,0), so a sprite never tears mid-frame.
//
// Ports
//   vga_clk      in   1   pixel clock, all logic on rising edge
//   reset        in   1   synchronous, active-high
//   spr_x_in     in   10  sprite origin X          (SPRITE_WINDOW_EN)
//   spr_y_in     in   10  sprite origin Y          (SPRITE_WINDOW_EN)
//   sprite_on    out  1   pixel inside window      (SPRITE_WINDOW_EN)
//   sprite_addr  out  11  sprite ROM address       (SPRITE_WINDOW_EN)
//   DrawX        out  10  pixel column 0..H_TOT-1
//   DrawY        out  10  line 0..V_TOT-1
//   hs           out  1   horizontal sync, active-low
//   vs           out  1   vertical sync, active-low
//   blank        out  1   1 = visible region
//   frame_start  out  1   1-cycle pulse while outputs show (0,0)
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
`ifdef SPRITE_WINDOW_EN
   ,
   parameter int SPR_W     = 21,
   parameter int SPR_H     = 45
`endif
) (
   input  logic        vga_clk,
   input  logic        reset,
`ifdef SPRITE_WINDOW_EN
   input  logic [9:0]  spr_x_in,
   input  logic [9:0]  spr_y_in,
   output logic        sprite_on,
   output logic [10:0] sprite_addr,
`endif
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        hs,
   output logic        vs,
   output logic        blank,
   output logic        frame_start
);

   localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
   localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_BEGIN   = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEGIN   = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

   // raster counters
   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic       h_wrap;
   logic       at_origin;

   // registered timing outputs
   logic [9:0] draw_x_q, draw_x_d;
   logic [9:0] draw_y_q, draw_y_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       blank_q, blank_d;
   logic       frame_start_q, frame_start_d;

   // -------------------------------------------------------------------------
   // Counter next-state
   // -------------------------------------------------------------------------
   always_comb begin
      h_wrap    = (h_cnt_q == H_LAST);
      at_origin = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

      h_cnt_d = h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (h_wrap) begin
         h_cnt_d = 10'd0;
         if (v_cnt_q == V_LAST) begin
            v_cnt_d = 10'd0;
         end else begin
            v_cnt_d = v_cnt_q + 10'd1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Timing decode of the current counter position
   // -------------------------------------------------------------------------
   always_comb begin
      draw_x_d      = h_cnt_q;
      draw_y_d      = v_cnt_q;
      blank_d       = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
      hs_d          = !((h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END));
      vs_d          = !((v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END));
      frame_start_d = at_origin;
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         h_cnt_q       <= 10'd0;
         v_cnt_q       <= 10'd0;
         draw_x_q      <= 10'd0;
         draw_y_q      <= 10'd0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         blank_q       <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         draw_x_q      <= draw_x_d;
         draw_y_q      <= draw_y_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_q       <= blank_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign DrawX       = draw_x_q;
   assign DrawY       = draw_y_q;
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign blank       = blank_q;
   assign frame_start = frame_start_q;

`ifdef SPRITE_WINDOW_EN
   // -------------------------------------------------------------------------
   // Sprite window
   // -------------------------------------------------------------------------
   localparam logic [10:0] SPR_W11 = 11'(SPR_W);
   localparam logic [10:0] SPR_H11 = 11'(SPR_H);

   logic [9:0]  ox_q, ox_d;
   logic [9:0]  oy_q, oy_d;
   logic [10:0] x_ext, y_ext, ox_ext, oy_ext;
   logic [10:0] dx, dy;
   logic        in_x, in_y;
   logic        sprite_on_q, sprite_on_d;
   logic [10:0] sprite_addr_q, sprite_addr_d;

   // The origin used for decode is the one being captured at (0,0), so the
   // whole frame, including its first pixel, sees one consistent origin.
   always_comb begin
      ox_d = ox_q;
      oy_d = oy_q;
      if (at_origin) begin
         ox_d = spr_x_in;
         oy_d = spr_y_in;
      end
   end

   // 11-bit compares keep ox+SPR_W from wrapping for windows near the edge.
   always_comb begin
      x_ext  = {1'b0, h_cnt_q};
      y_ext  = {1'b0, v_cnt_q};
      ox_ext = {1'b0, ox_d};
      oy_ext = {1'b0, oy_d};
      dx     = x_ext - ox_ext;
      dy     = y_ext - oy_ext;
      in_x   = (x_ext >= ox_ext) && (x_ext < (ox_ext + SPR_W11));
      in_y   = (y_ext >= oy_ext) && (y_ext < (oy_ext + SPR_H11));

      sprite_on_d   = blank_d && in_x && in_y;
      sprite_addr_d = 11'd0;
      if (sprite_on_d) begin
         sprite_addr_d = (dy * SPR_W11) + dx;
      end
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         ox_q          <= 10'd0;
         oy_q          <= 10'd0;
         sprite_on_q   <= 1'b0;
         sprite_addr_q <= 11'd0;
      end else begin
         ox_q          <= ox_d;
         oy_q          <= oy_d;
         sprite_on_q   <= sprite_on_d;
         sprite_addr_q <= sprite_addr_d;
      end
   end

   assign sprite_on   = sprite_on_q;
   assign sprite_addr = sprite_addr_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Horizontal geometry is the full 640-pixel VGA line.  The vertical
//   geometry is shortened (46 visible lines, 52 total) so that complete
//   frames fit in a short run; the vertical sync/blank/wrap behaviour is the
//   same function of the parameters as at full size.  The reference model
//   derives the raster position from the number of clock edges since reset
//   release and decodes it with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int H_TOT  = 800;
   localparam int V_VIS  = 46;
   localparam int V_FP   = 2;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 2;
   localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int FRAME  = H_TOT * V_TOT;
`ifdef SPRITE_WINDOW_EN
   localparam int MID_Y  = 46;
`else
   localparam int MID_Y  = 5;
`endif
   localparam logic [35:0] RESET_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0};

   logic        vga_clk = 1'b0;
   logic        reset   = 1'b1;
   logic [9:0]  DrawX, DrawY;
   logic        hs, vs, blank, frame_start;
   logic [35:0] obs;
`ifdef SPRITE_WINDOW_EN
   logic [9:0]  spr_x = 10'd630;
   logic [9:0]  spr_y = 10'd36;
   logic        sprite_on;
   logic [10:0] sprite_addr;
   logic [9:0]  fox = 10'd0;
   logic [9:0]  foy = 10'd0;
`endif

   int          checks = 0;
   int          errors = 0;
   int unsigned edges  = 0;
   logic        rst_seen = 1'b1;

   always #5 vga_clk = ~vga_clk;

   vga_timing_gen #(
      .V_VISIBLE (V_VIS),
      .V_FP      (V_FP),
      .V_SYNC    (V_SYNC),
      .V_BP      (V_BP)
   ) dut (
      .vga_clk     (vga_clk),
      .reset       (reset),
`ifdef SPRITE_WINDOW_EN
      .spr_x_in    (spr_x),
      .spr_y_in    (spr_y),
      .sprite_on   (sprite_on),
      .sprite_addr (sprite_addr),
`endif
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .hs          (hs),
      .vs          (vs),
      .blank       (blank),
      .frame_start (frame_start)
   );

`ifdef SPRITE_WINDOW_EN
   assign obs = {DrawX, DrawY, hs, vs, blank, frame_start, sprite_on, sprite_addr};
`else
   assign obs = {DrawX, DrawY, hs, vs, blank, frame_start, 1'b0, 11'd0};
`endif

   // Edge counter since reset release; the sprite origin of a frame is the
   // input value present on the edge that starts it.
   always @(posedge vga_clk) begin
      rst_seen <= reset;
      if (reset) begin
         edges <= 0;
      end else begin
`ifdef SPRITE_WINDOW_EN
         if (edges % FRAME == 0) begin
            fox <= spr_x;
            foy <= spr_y;
         end
`endif
         edges <= edges + 1;
      end
   end

   function automatic logic [35:0] model_vec();
      int   p, x, y, e_addr;
      logic e_hs, e_vs, e_bl, e_fs, e_on;
      if (rst_seen) return RESET_VEC;
      p    = int'((edges - 1) % FRAME);
      x    = p % H_TOT;
      y    = p / H_TOT;
      e_bl = (x < 640) && (y < V_VIS);
      e_hs = !(x >= 656 && x < 752);
      e_vs = !(y >= V_VIS + V_FP && y < V_VIS + V_FP + V_SYNC);
      e_fs = (p == 0);
      e_on = 1'b0;
      e_addr = 0;
`ifdef SPRITE_WINDOW_EN
      if (e_bl && x >= int'(fox) && x < int'(fox) + 21 &&
          y >= int'(foy) && y < int'(foy) + 45) begin
         e_on   = 1'b1;
         e_addr = (y - int'(foy)) * 21 + (x - int'(fox));
      end
`endif
      return {10'(x), 10'(y), e_hs, e_vs, e_bl, e_fs, e_on, 11'(e_addr)};
   endfunction

   task automatic test_reset();
      logic [35:0] exp;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge vga_clk);
         checks++;
         if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_hold[%0d]: actual %h required %h", i, obs, RESET_VEC);
         end
      end
      reset = 1'b0;
      @(negedge vga_clk);
      exp = model_vec();
      checks++;
      if ({DrawX, DrawY, hs, vs, blank, frame_start} !== {10'd0, 10'd0, 4'b1111}) begin
         errors++;
         $display("FAIL reset_release_first: actual x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b required 0 0 1 1 1 1",
                  DrawX, DrawY, hs, vs, blank, frame_start);
      end
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL reset_release_model: actual %h required %h", obs, exp);
      end
      @(negedge vga_clk);
      checks++;
      if (DrawX !== 10'd1 || frame_start !== 1'b0) begin
         errors++;
         $display("FAIL second_pixel: actual x=%0d fs=%b required x=1 fs=0", DrawX, frame_start);
      end
   endtask

   task automatic test_line();
      logic [35:0] exp;
      int  blank_fall = -1, hs_first = -1, hs_last = -1, hs_cnt = 0, prev_x = 1;
      int  last_x = -1;
      bit  done = 1'b0;
      for (int i = 0; i < 900 && !done; i++) begin
         @(negedge vga_clk);
         exp = model_vec();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL line_model @%0d: actual %h required %h", edges, obs, exp);
         end
         if (DrawY == 10'd0) begin
            if (blank === 1'b0 && blank_fall < 0) blank_fall = int'(DrawX);
            if (hs === 1'b0) begin
               hs_cnt++;
               if (hs_first < 0) hs_first = int'(DrawX);
               hs_last = int'(DrawX);
            end
         end
         if (DrawY == 10'd1 && DrawX == 10'd0) begin
            done   = 1'b1;
            last_x = prev_x;
         end
         prev_x = int'(DrawX);
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL line_wrap_timeout: actual no wrap to (0,1) required wrap within 900 cycles");
      end
      checks++;
      if (last_x != 799) begin
         errors++;
         $display("FAIL line_last_x: actual %0d required 799", last_x);
      end
      checks++;
      if (blank_fall != 640) begin
         errors++;
         $display("FAIL blank_fall_x: actual %0d required 640", blank_fall);
      end
      checks++;
      if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
         errors++;
         $display("FAIL hs_window: actual cnt=%0d first=%0d last=%0d required 96 656 751",
                  hs_cnt, hs_first, hs_last);
      end
   endtask

   task automatic test_frame();
      logic [35:0] exp;
      int  vs_cnt = 0, vs_first = -1, vs_last = -1, prev_y = 0, interval = -1;
      bit  wrap_seen = 1'b0, done = 1'b0;
`ifdef SPRITE_WINDOW_EN
      int  spr_cnt = 0, min_x = 9999, max_x = -1, min_y = 9999, max_y = -1;
      int  chg_at = int'($urandom_range(1000, FRAME / 2));
`endif
      for (int i = 0; i < FRAME + 10 && !done; i++) begin
`ifdef SPRITE_WINDOW_EN
         if (i == chg_at) begin
            spr_x = 10'($urandom_range(0, 639));
            spr_y = 10'($urandom_range(0, V_VIS - 1));
         end
         if (i == FRAME - 1600) begin
            spr_x = 10'd100;
            spr_y = 10'd1;
         end
`endif
         @(negedge vga_clk);
         exp = model_vec();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL frame_model @%0d: actual %h required %h", edges, obs, exp);
         end
         if (vs === 1'b0) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = int'(DrawY);
            vs_last = int'(DrawY);
         end
         if (prev_y == V_TOT - 1 && DrawY == 10'd0) wrap_seen = 1'b1;
         prev_y = int'(DrawY);
`ifdef SPRITE_WINDOW_EN
         if (sprite_on === 1'b1) begin
            spr_cnt++;
            if (int'(DrawX) < min_x) min_x = int'(DrawX);
            if (int'(DrawX) > max_x) max_x = int'(DrawX);
            if (int'(DrawY) < min_y) min_y = int'(DrawY);
            if (int'(DrawY) > max_y) max_y = int'(DrawY);
         end
`endif
         if (frame_start === 1'b1) begin
            done     = 1'b1;
            interval = int'(edges) - 1;
         end
      end
      checks++;
      if (interval != FRAME) begin
         errors++;
         $display("FAIL frame_start_interval: actual %0d required %0d", interval, FRAME);
      end
      checks++;
      if (vs_cnt != 1600 || vs_first != V_VIS + V_FP || vs_last != V_VIS + V_FP + 1) begin
         errors++;
         $display("FAIL vs_window: actual cnt=%0d first=%0d last=%0d required 1600 %0d %0d",
                  vs_cnt, vs_first, vs_last, V_VIS + V_FP, V_VIS + V_FP + 1);
      end
      checks++;
      if (!wrap_seen) begin
         errors++;
         $display("FAIL drawy_wrap: actual no %0d->0 wrap required wrap", V_TOT - 1);
      end
`ifdef SPRITE_WINDOW_EN
      checks++;
      if (spr_cnt != 100 || min_x != 630 || max_x != 639 || min_y != 36 || max_y != 45) begin
         errors++;
         $display("FAIL sprite_edge_window: actual cnt=%0d x=%0d..%0d y=%0d..%0d required 100 630..639 36..45",
                  spr_cnt, min_x, max_x, min_y, max_y);
      end
`endif
   endtask

`ifdef SPRITE_WINDOW_EN
   task automatic test_sprite();
      logic [35:0] exp;
      int  chg_at = int'($urandom_range(200, 30000));
      bit  hit_a = 1'b0, hit_b = 1'b0, hit_c = 1'b0, done = 1'b0;
      for (int i = 0; i < 47 * H_TOT && !done; i++) begin
         if (i == chg_at) begin
            spr_x = 10'd0;
            spr_y = 10'd0;
         end
         @(negedge vga_clk);
         exp = model_vec();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL sprite_model @%0d: actual %h required %h", edges, obs, exp);
         end
         if (DrawX == 10'd100 && DrawY == 10'd1) begin
            hit_a = 1'b1;
            checks++;
            if (sprite_on !== 1'b1 || sprite_addr !== 11'd0) begin
               errors++;
               $display("FAIL sprite_origin_px: actual on=%b addr=%0d required on=1 addr=0", sprite_on, sprite_addr);
            end
         end
         if (DrawX == 10'd120 && DrawY == 10'd45) begin
            hit_b = 1'b1;
            checks++;
            if (sprite_on !== 1'b1 || sprite_addr !== 11'd944) begin
               errors++;
               $display("FAIL sprite_last_px: actual on=%b addr=%0d required on=1 addr=944", sprite_on, sprite_addr);
            end
         end
         if (DrawX == 10'd121 && DrawY == 10'd1) begin
            hit_c = 1'b1;
            checks++;
            if (sprite_on !== 1'b0 || sprite_addr !== 11'd0) begin
               errors++;
               $display("FAIL sprite_right_off: actual on=%b addr=%0d required on=0 addr=0", sprite_on, sprite_addr);
            end
         end
         if (DrawY == 10'd46) done = 1'b1;
      end
      checks++;
      if (!(hit_a && hit_b && hit_c)) begin
         errors++;
         $display("FAIL sprite_points_reached: actual %b%b%b required 111", hit_a, hit_b, hit_c);
      end
   endtask
`endif

   task automatic test_mid_reset();
      logic [35:0] exp;
      bit done = 1'b0;
      int hold = int'($urandom_range(1, 6));
      for (int i = 0; i < FRAME && !done; i++) begin
         @(negedge vga_clk);
         exp = model_vec();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL pre_reset_model @%0d: actual %h required %h", edges, obs, exp);
         end
         if (DrawX == 10'd300 && DrawY == 10'(MID_Y)) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL mid_reset_reach: actual position not reached required (300,%0d)", MID_Y);
      end
      reset = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge vga_clk);
         checks++;
         if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL mid_reset_hold[%0d]: actual %h required %h", i, obs, RESET_VEC);
         end
      end
      reset = 1'b0;
      @(negedge vga_clk);
      checks++;
      if ({DrawX, DrawY, hs, vs, blank, frame_start} !== {10'd0, 10'd0, 4'b1111}) begin
         errors++;
         $display("FAIL mid_reset_resume: actual x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b required 0 0 1 1 1 1",
                  DrawX, DrawY, hs, vs, blank, frame_start);
      end
`ifdef SPRITE_WINDOW_EN
      checks++;
      if (sprite_on !== 1'b1 || sprite_addr !== 11'd0) begin
         errors++;
         $display("FAIL mid_reset_sprite: actual on=%b addr=%0d required on=1 addr=0", sprite_on, sprite_addr);
      end
`endif
      for (int i = 0; i < 1000; i++) begin
         @(negedge vga_clk);
         exp = model_vec();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL post_reset_model @%0d: actual %h required %h", edges, obs, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_frame();
`ifdef SPRITE_WINDOW_EN
      test_sprite();
`endif
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
